// File: rtl/buyruk_getir.sv
`default_nettype none
// ============================================================================
// Module      : buyruk_getir
// Description : Instruction fetch stage. Single-outstanding memory handshake,
//               holding output register, branch redirect with stale-response drop.
// Revision    : 1.0
// ============================================================================
module buyruk_getir #(
    parameter logic [31:0] BASLANGIC_PS = 32'h4000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_yanit_gecerli_i,
    input  logic [31:0] bellek_buyruk_i,
    input  logic        dallanma_gecerli_i,
    input  logic [31:0] dallanma_ps_i,
    input  logic        kuyruk_durdur_i,
    input  logic        boru_durdur_i,
    output logic [31:0] buyruk_o,
    output logic        buyruk_gecerli_o,
    output logic [31:0] ps_o,
    output logic        ps_atladi_o
);

    localparam logic [1:0] c_BOSTA = 2'd0;
    localparam logic [1:0] c_ISTEK = 2'd1;
    localparam logic [1:0] c_YANIT = 2'd2;
    localparam logic [1:0] c_BEKLE = 2'd3;

    logic [1:0]  r_durum;
    logic [1:0]  w_sonraki_durum;
    logic [31:0] r_ps;
    logic [31:0] r_istek_ps;
    logic        r_atla;
    logic        r_at;
    logic [31:0] r_buyruk;
    logic        r_gecerli;
    logic [31:0] r_ps_cikis;
    logic        r_atladi;

    logic        w_tuket;
    logic        w_istek;
    logic        w_kabul;
    logic        w_yakala;

    // A request is only offered when the output register will be free at the
    // edge, so YANIT is always entered with an empty register.
    always_comb begin
        w_tuket  = r_gecerli & ~kuyruk_durdur_i & ~boru_durdur_i;
        w_istek  = (r_durum == c_ISTEK) & (~r_gecerli | w_tuket);
        w_kabul  = w_istek & bellek_hazir_i;
        w_yakala = (r_durum == c_YANIT) & bellek_yanit_gecerli_i & ~r_at & ~dallanma_gecerli_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_durum <= c_BOSTA;
        end else begin
            r_durum <= w_sonraki_durum;
        end
    end

    always_comb begin
        w_sonraki_durum = r_durum;
        case (r_durum)
            c_BOSTA: w_sonraki_durum = c_ISTEK;
            c_ISTEK: begin
                if (w_kabul) begin
                    w_sonraki_durum = c_YANIT;
                end else if (!dallanma_gecerli_i && r_gecerli && !w_tuket) begin
                    w_sonraki_durum = c_BEKLE;
                end
            end
            c_YANIT: begin
                if (bellek_yanit_gecerli_i) begin
                    w_sonraki_durum = c_ISTEK;
                end
            end
            c_BEKLE: begin
                if (dallanma_gecerli_i || w_tuket) begin
                    w_sonraki_durum = c_ISTEK;
                end
            end
            default: w_sonraki_durum = c_BOSTA;
        endcase
    end

    always_comb begin
        bellek_istek_o   = w_istek;
        bellek_adres_o   = r_ps;
        buyruk_o         = r_buyruk;
        buyruk_gecerli_o = r_gecerli;
        ps_o             = r_ps_cikis;
        ps_atladi_o      = r_atladi;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ps       <= BASLANGIC_PS;
            r_istek_ps <= 32'h0;
            r_atla     <= 1'b1;
            r_at       <= 1'b0;
            r_buyruk   <= 32'h0;
            r_gecerli  <= 1'b0;
            r_ps_cikis <= 32'h0;
            r_atladi   <= 1'b0;
        end else begin
            if (w_kabul) begin
                r_istek_ps <= r_ps;
                r_ps       <= r_ps + 32'd4;
            end
            if (dallanma_gecerli_i) begin
                // A response landing in the redirect cycle is simply dropped;
                // only a still-pending one needs the discard flag.
                r_ps      <= dallanma_ps_i & ~32'h3;
                r_atla    <= 1'b1;
                r_gecerli <= 1'b0;
                r_at      <= w_kabul | ((r_durum == c_YANIT) & ~bellek_yanit_gecerli_i & r_at)
                           | ((r_durum == c_YANIT) & ~bellek_yanit_gecerli_i);
            end else begin
                if ((r_durum == c_YANIT) && bellek_yanit_gecerli_i) begin
                    r_at <= 1'b0;
                end
                if (w_yakala) begin
                    r_buyruk   <= bellek_buyruk_i;
                    r_ps_cikis <= r_istek_ps;
                    r_atladi   <= r_atla;
                    r_gecerli  <= 1'b1;
                    r_atla     <= 1'b0;
                end else if (w_tuket) begin
                    r_gecerli <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/buyruk_getir.md
Name: buyruk_getir

Overview:
- Fetch stage directly upstream of the instruction queue.
- Generates word-aligned fetch addresses and runs a single-outstanding request/response handshake with instruction memory/cache.
- Holds each returned 32-bit word in an output register until the queue and pipeline consume it.
- Handles branch redirects, including discarding stale in-flight responses, and flags the first word after reset or redirect so the queue restarts alignment.

Parameters:
- BASLANGIC_PS, 32'h4000_0000, fetch address after reset (bits [1:0] must be 0).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-low reset
- bellek_istek_o  output  1  fetch request valid
- bellek_adres_o  output  32  fetch address (word-aligned, [1:0]=0)
- bellek_hazir_i  input  1  memory accepts request this cycle
- bellek_yanit_gecerli_i  input  1  response word valid this cycle
- bellek_buyruk_i  input  32  response word
- dallanma_gecerli_i  input  1  redirect request (1-cycle pulse)
- dallanma_ps_i  input  32  redirect target; bits [1:0] ignored (forced 0)
- kuyruk_durdur_i  input  1  queue needs extra cycle; hold current word
- boru_durdur_i  input  1  pipeline stall; hold current word
- buyruk_o  output  32  held instruction word
- buyruk_gecerli_o  output  1  buyruk_o valid
- ps_o  output  32  address of buyruk_o
- ps_atladi_o  output  1  buyruk_o is first word after reset/redirect

Behaviour:
- Reset (rst_i=0 at a clk edge):
  - State BOSTA; ps_r=BASLANGIC_PS; output register invalid; atla_r=1; discard flag clear.
  - Outputs: bellek_istek_o=0, buyruk_gecerli_o=0, ps_atladi_o=0, buyruk_o=0, ps_o=0.
  - Reset mid-transaction abandons the outstanding request.
  - A response arriving in the first 2 cycles after reset release is ignored.
- States:
  - BOSTA: always goes to ISTEK next cycle.
  - ISTEK: bellek_istek_o=1, bellek_adres_o=ps_r. On bellek_hazir_i: istek_ps<=ps_r, ps_r<=ps_r+4 (32-bit wrap), go to YANIT.
  - YANIT: waits for bellek_yanit_gecerli_i.
  - BEKLE: output register full and stalled.
- Memory handshake:
  - At most one outstanding request.
  - Memory may return the response no earlier than the cycle after acceptance.
  - bellek_adres_o may change without acceptance only on redirect.
- Consume: occurs in a cycle where buyruk_gecerli_o=1, kuyruk_durdur_i=0 and boru_durdur_i=0.
- Response in YANIT, not discarded:
  - Capture buyruk_o<=bellek_buyruk_i, ps_o<=istek_ps, gecerli<=1, ps_atladi_o<=atla_r, atla_r<=0.
  - Capture is legal only if the output register is empty or consumed in the same cycle; otherwise the response is held off by going to BEKLE first.
- Leaving YANIT:
  - On capture with no stall, go to ISTEK.
  - If the register is still held, go to BEKLE.
- BEKLE → ISTEK when the held word is consumed.
- Throughput: one word per 2 cycles with zero-latency memory.
- Output register holds buyruk_o, ps_o and ps_atladi_o unchanged while valid and not consumed. On consume with no new capture, gecerli<=0.
- Redirect (dallanma_gecerli_i=1), highest priority, effective next cycle:
  - ps_r<=target&~3, output register invalidated, atla_r<=1.
  - In ISTEK without hazir: next cycle requests the target.
  - In ISTEK with hazir (accepted same cycle), or in YANIT: set discard flag, go to YANIT.
  - Next response is dropped; discard clears; go to ISTEK with the new ps_r.
  - A response arriving in the redirect cycle itself is dropped, with no discard flag set for it.
  - In BEKLE: go to ISTEK.
- Simultaneous consume and redirect: redirect wins; word counts as consumed; no later word from the old stream ever appears.
- kuyruk_durdur_i and boru_durdur_i are ignored when buyruk_gecerli_o=0.

Test Plan:
- Reset release, memory hazir=1, response 1 cycle after accept:
  - Adresses 0x40000000, 0x40000004, 0x40000008 issued.
  - First word out with ps_o=0x40000000, ps_atladi_o=1; subsequent words have ps_atladi_o=0.
- Word 0x00010001 valid; kuyruk_durdur_i=1 for 1 cycle:
  - buyruk_o held 2 cycles.
  - Next request issued only after consume.
- Redirect to 0x40000102 while in YANIT:
  - Old response (addr 0x40000008) dropped.
  - Next request address 0x40000100.
  - Delivered word has ps_o=0x40000100, ps_atladi_o=1.
- Redirect in the same cycle a response arrives and the old word is consumed: neither word is visible; buyruk_gecerli_o=0 the next cycle.
- boru_durdur_i=1 for 5 cycles with a word held:
  - State BEKLE; bellek_istek_o=0 throughout.
  - Stall release → request issued the next cycle.
- rst_i=0 while a request is outstanding:
  - All outputs 0 next cycle.
  - A late response is ignored.
  - Fetch restarts at BASLANGIC_PS.
